// File: rtl/tc_pl_cap_gain_pkg.sv
// Shared types and helpers for the sequenced capture-channel gain controller.
package tc_pl_cap_gain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RELAY,
    ST_SETTLE,
    ST_DACA,
    ST_DACB,
    ST_LMH,
    ST_DONE
  } gain_state_t;

  // Upper bounds for the generic table-slicing helper.
  localparam int unsigned TBL_MAX = 1024;
  localparam int unsigned ENT_MAX = 64;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // clk cycles from CSN fall to the end of the trailing CSN-high gap.
  function automatic int unsigned frame_cyc(input int unsigned w, input int unsigned div);
    return (2 * w + 2) * div;
  endfunction

  function automatic logic [ENT_MAX-1:0] entry_slice(input logic [TBL_MAX-1:0] tbl,
                                                     input int unsigned idx,
                                                     input int unsigned w);
    logic [TBL_MAX-1:0] sh;
    sh = tbl >> (idx * w);
    return sh[ENT_MAX-1:0] & ((ENT_MAX'(1) << w) - ENT_MAX'(1));
  endfunction

endpackage

// File: rtl/tc_pl_cap_gain_shift.sv
// Generic MSB-first serializer: SCK idles low, SDI changes on falling edges,
// frame = setup half, 2*len SCK halves, one CSN-high gap half.
module tc_pl_cap_gain_shift
  import tc_pl_cap_gain_pkg::*;
#(
  parameter int unsigned W_MAX   = 32,
  parameter int unsigned SCK_DIV = 4,
  parameter int unsigned LEN_W   = clog2(W_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [W_MAX-1:0] data,
  output logic             done,
  output logic             sck,
  output logic             csn,
  output logic             sdi
);

  localparam int unsigned DIV_W = clog2(SCK_DIV);
  localparam int unsigned HC_W  = LEN_W + 1;

  logic             active;
  logic [DIV_W-1:0] div;
  logic [HC_W-1:0]  half;
  logic [HC_W-1:0]  nxt_half;
  logic [HC_W-1:0]  last_half;
  logic [LEN_W-1:0] len_q;
  logic [W_MAX-1:0] sr;
  logic [W_MAX-1:0] aligned;
  logic             div_end;

  assign aligned   = data << (W_MAX - 32'(len));
  assign div_end   = active && (div == DIV_W'(SCK_DIV - 1));
  assign last_half = {len_q, 1'b0} + HC_W'(1);
  assign nxt_half  = half + HC_W'(1);
  // Combinational so the next frame can start on the same edge.
  assign done      = div_end && (half == last_half);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active <= 1'b0;
      div    <= '0;
      half   <= '0;
      len_q  <= '0;
      sr     <= '0;
      sck    <= 1'b0;
      csn    <= 1'b1;
      sdi    <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      div    <= '0;
      half   <= '0;
      len_q  <= len;
      sr     <= aligned;
      sck    <= 1'b0;
      csn    <= 1'b0;
      sdi    <= aligned[W_MAX-1];
    end else if (div_end) begin
      div <= '0;
      if (half == last_half) begin
        active <= 1'b0;
      end else begin
        half <= nxt_half;
        if (nxt_half == last_half) begin
          csn <= 1'b1;
          sck <= 1'b0;
          sdi <= 1'b0;
        end else if (nxt_half[0]) begin
          sck <= 1'b1;
        end else begin
          sck <= 1'b0;
          sdi <= sr[W_MAX-2];
          sr  <= {sr[W_MAX-2:0], 1'b0};
        end
      end
    end else if (active) begin
      div <= div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/tc_pl_cap_gain_seq.sv
// Sequenced gain controller: relays, settle delay, DAC A/B and FDA frames.
// gain_en to gain_cmpt latency is 3 + del + 2*FRAME(DAC_W) + FRAME(LMH_W) (DONE registers completion).
module tc_pl_cap_gain_seq
  import tc_pl_cap_gain_pkg::*;
#(
  parameter int unsigned GAIN_NUM = 8,
  parameter int unsigned GAIN_W   = 4,
  parameter int unsigned DAC_W    = 32,
  parameter int unsigned LMH_W    = 16,
  parameter int unsigned RELAY_W  = 4,
  parameter int unsigned DEL_W    = 32,
  parameter int unsigned SCK_DIV  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [GAIN_W-1:0]           gain_value,
  input  logic                        gain_en,
  input  logic                        gain_force,
  input  logic [DEL_W-1:0]            cap_gain_del,
  input  logic [GAIN_NUM*DAC_W-1:0]   gain_dacA_tbl,
  input  logic [GAIN_NUM*DAC_W-1:0]   gain_dacB_tbl,
  input  logic [GAIN_NUM*LMH_W-1:0]   gain_lmh_tbl,
  input  logic [GAIN_NUM*RELAY_W-1:0] gain_relay_tbl,
  output logic                        gain_busy,
  output logic                        gain_cmpt,
  output logic                        gain_err,
  output logic [GAIN_W-1:0]           gain_cur,
  output logic                        gain_cur_vld,
  output logic [RELAY_W-1:0]          relay_out,
  output logic                        DAC_SCK,
  output logic                        DAC_CSN,
  output logic                        DAC_SDI,
  output logic                        FDA_SCK,
  output logic                        FDA_CSN,
  output logic                        FDA_SDI
);

  localparam int unsigned SH_W  = (DAC_W > LMH_W) ? DAC_W : LMH_W;
  localparam int unsigned LEN_W = clog2(SH_W + 1);

  gain_state_t       state, state_n;
  logic [GAIN_W-1:0] idx_q;
  logic [DAC_W-1:0]  dac_a_q, dac_b_q;
  logic [LMH_W-1:0]  lmh_q;
  logic [DEL_W-1:0]  del_q, cnt;
  logic              sh_start, sh_done, sh_sck, sh_csn, sh_sdi;
  logic [LEN_W-1:0]  sh_len;
  logic [SH_W-1:0]   sh_data;
  logic              in_range, same_gain, accept, dac_sel, fda_sel;

  assign in_range  = 32'(gain_value) < GAIN_NUM;
  assign same_gain = gain_cur_vld && (gain_value == gain_cur) && !gain_force;
  assign accept    = gain_en && (state == ST_IDLE) && in_range && !same_gain;

  always_comb begin
    state_n  = state;
    sh_start = 1'b0;
    sh_len   = LEN_W'(DAC_W);
    sh_data  = SH_W'(dac_a_q);
    case (state)
      ST_IDLE:   if (accept) state_n = ST_RELAY;
      ST_RELAY: begin
        if (del_q == '0) begin
          state_n  = ST_DACA;
          sh_start = 1'b1;
        end else begin
          state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == del_q - DEL_W'(1)) begin
          state_n  = ST_DACA;
          sh_start = 1'b1;
        end
      end
      ST_DACA: begin
        if (sh_done) begin
          state_n  = ST_DACB;
          sh_start = 1'b1;
          sh_data  = SH_W'(dac_b_q);
        end
      end
      ST_DACB: begin
        if (sh_done) begin
          state_n  = ST_LMH;
          sh_start = 1'b1;
          sh_len   = LEN_W'(LMH_W);
          sh_data  = SH_W'(lmh_q);
        end
      end
      ST_LMH:    if (sh_done) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      idx_q        <= '0;
      dac_a_q      <= '0;
      dac_b_q      <= '0;
      lmh_q        <= '0;
      del_q        <= '0;
      cnt          <= '0;
      relay_out    <= '0;
      gain_cur     <= '0;
      gain_cur_vld <= 1'b0;
      gain_busy    <= 1'b0;
      gain_cmpt    <= 1'b0;
      gain_err     <= 1'b0;
    end else begin
      state     <= state_n;
      gain_cmpt <= 1'b0;
      gain_err  <= 1'b0;
      if (gain_en) begin
        if (state != ST_IDLE || !in_range) begin
          gain_err <= 1'b1;
        end else if (same_gain) begin
          gain_cmpt <= 1'b1;
        end else begin
          idx_q     <= gain_value;
          dac_a_q   <= DAC_W'(entry_slice(TBL_MAX'(gain_dacA_tbl), 32'(gain_value), DAC_W));
          dac_b_q   <= DAC_W'(entry_slice(TBL_MAX'(gain_dacB_tbl), 32'(gain_value), DAC_W));
          lmh_q     <= LMH_W'(entry_slice(TBL_MAX'(gain_lmh_tbl), 32'(gain_value), LMH_W));
          relay_out <= RELAY_W'(entry_slice(TBL_MAX'(gain_relay_tbl), 32'(gain_value), RELAY_W));
          del_q     <= cap_gain_del;
          gain_busy <= 1'b1;
        end
      end
      cnt <= (state == ST_SETTLE) ? cnt + DEL_W'(1) : '0;
      if (state == ST_DONE) begin
        gain_cmpt    <= 1'b1;
        gain_busy    <= 1'b0;
        gain_cur     <= idx_q;
        gain_cur_vld <= 1'b1;
      end
    end
  end

  tc_pl_cap_gain_shift #(
    .W_MAX   (SH_W),
    .SCK_DIV (SCK_DIV),
    .LEN_W   (LEN_W)
  ) u_shift (
    .clk   (clk),
    .rst   (rst),
    .start (sh_start),
    .len   (sh_len),
    .data  (sh_data),
    .done  (sh_done),
    .sck   (sh_sck),
    .csn   (sh_csn),
    .sdi   (sh_sdi)
  );

  assign dac_sel = (state == ST_DACA) || (state == ST_DACB);
  assign fda_sel = (state == ST_LMH);

  assign DAC_SCK = dac_sel & sh_sck;
  assign DAC_CSN = dac_sel ? sh_csn : 1'b1;
  assign DAC_SDI = dac_sel & sh_sdi;
  assign FDA_SCK = fda_sel & sh_sck;
  assign FDA_CSN = fda_sel ? sh_csn : 1'b1;
  assign FDA_SDI = fda_sel & sh_sdi;

endmodule

// File: tb/tb_tc_pl_cap_gain_seq.sv
// Scoreboard bench for tc_pl_cap_gain_seq with a request-level reference model.
module tb_tc_pl_cap_gain_seq;

  localparam int GN   = 8;
  localparam int GW   = 4;
  localparam int DW   = 32;
  localparam int LW   = 16;
  localparam int RW   = 4;
  localparam int DELW = 32;
  localparam int DIV  = 4;
  localparam int FA   = (2 * DW + 2) * DIV;
  localparam int FL   = (2 * LW + 2) * DIV;

  logic              clk, rst;
  logic [GW-1:0]     gain_value;
  logic              gain_en, gain_force;
  logic [DELW-1:0]   cap_gain_del;
  logic [GN*DW-1:0]  gain_dacA_tbl, gain_dacB_tbl;
  logic [GN*LW-1:0]  gain_lmh_tbl;
  logic [GN*RW-1:0]  gain_relay_tbl;
  logic              gain_busy, gain_cmpt, gain_err, gain_cur_vld;
  logic [GW-1:0]     gain_cur;
  logic [RW-1:0]     relay_out;
  logic              DAC_SCK, DAC_CSN, DAC_SDI, FDA_SCK, FDA_CSN, FDA_SDI;

  tc_pl_cap_gain_seq #(
    .GAIN_NUM (GN), .GAIN_W (GW), .DAC_W (DW), .LMH_W (LW),
    .RELAY_W (RW), .DEL_W (DELW), .SCK_DIV (DIV)
  ) dut (
    .clk (clk), .rst (rst),
    .gain_value (gain_value), .gain_en (gain_en), .gain_force (gain_force),
    .cap_gain_del (cap_gain_del),
    .gain_dacA_tbl (gain_dacA_tbl), .gain_dacB_tbl (gain_dacB_tbl),
    .gain_lmh_tbl (gain_lmh_tbl), .gain_relay_tbl (gain_relay_tbl),
    .gain_busy (gain_busy), .gain_cmpt (gain_cmpt), .gain_err (gain_err),
    .gain_cur (gain_cur), .gain_cur_vld (gain_cur_vld), .relay_out (relay_out),
    .DAC_SCK (DAC_SCK), .DAC_CSN (DAC_CSN), .DAC_SDI (DAC_SDI),
    .FDA_SCK (FDA_SCK), .FDA_CSN (FDA_CSN), .FDA_SDI (FDA_SDI)
  );

  typedef struct { int cyc; logic [GW-1:0] cur; } ev_t;
  typedef struct { int bus; logic [31:0] data; int len; int st; } fr_t;

  logic [31:0]   t_dac_a [GN];
  logic [31:0]   t_dac_b [GN];
  logic [LW-1:0] t_lmh   [GN];
  logic [RW-1:0] t_relay [GN];

  ev_t cmpt_q[$];
  ev_t err_q[$];
  fr_t fr_q[$];
  logic [GW-1:0] m_cur;
  bit            m_vld;
  logic [RW-1:0] m_relay;
  int busy_from, busy_to, last_c;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  task automatic model_reset();
    cmpt_q.delete();
    err_q.delete();
    fr_q.delete();
    m_cur = '0;
    m_vld = 1'b0;
    m_relay = '0;
    busy_from = 0;
    busy_to = 0;
  endtask

  task automatic check_reset(input string nm);
    chk(nm, 64'({relay_out, gain_cur, gain_cur_vld, gain_busy, gain_cmpt, gain_err,
                 DAC_SCK, DAC_CSN, DAC_SDI, FDA_SCK, FDA_CSN, FDA_SDI}), 64'(18'h00012));
  endtask

  // Issue one request and record what the controller must do in response.
  task automatic req(input logic [GW-1:0] v, input bit f, input int d);
    @(posedge clk);
    #1;
    gain_value = v;
    gain_force = f;
    cap_gain_del = DELW'(d);
    gain_en = 1'b1;
    last_c = cyc;
    if (cyc >= busy_from && cyc < busy_to) begin
      err_q.push_back('{cyc + 1, m_cur});
    end else if (int'(v) >= GN) begin
      err_q.push_back('{cyc + 1, m_cur});
    end else if (m_vld && v == m_cur && !f) begin
      cmpt_q.push_back('{cyc + 1, v});
    end else begin
      m_relay = t_relay[v];
      fr_q.push_back('{0, t_dac_a[v], DW, cyc + 2 + d});
      fr_q.push_back('{0, t_dac_b[v], DW, cyc + 2 + d + FA});
      fr_q.push_back('{1, 32'(t_lmh[v]), LW, cyc + 2 + d + 2 * FA});
      busy_from = cyc + 1;
      busy_to   = cyc + 3 + d + 2 * FA + FL;
      cmpt_q.push_back('{busy_to, v});
    end
    @(posedge clk);
    #1;
    gain_en = 1'b0;
    chk("relay_out", 64'(relay_out), 64'(m_relay));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((cmpt_q.size() != 0 || err_q.size() != 0 || fr_q.size() != 0 || cyc < busy_to)
           && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 4000) begin
      fail_now("wait_idle_timeout");
      cmpt_q.delete();
      err_q.delete();
      fr_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // Pulse and busy monitor.
  always @(negedge clk) begin
    if (rst) begin
      chk("gain_busy", 64'(gain_busy), 64'(cyc >= busy_from && cyc < busy_to));
      if (gain_cmpt) begin
        if (cmpt_q.size() == 0) fail_now("cmpt_unexpected");
        else begin
          ev_t e;
          e = cmpt_q.pop_front();
          chk("cmpt_cycle", 64'(cyc), 64'(e.cyc));
          chk("gain_cur", 64'(gain_cur), 64'(e.cur));
          chk("gain_cur_vld", 64'(gain_cur_vld), 64'(1));
          m_cur = e.cur;
          m_vld = 1'b1;
        end
      end
      if (gain_err) begin
        if (err_q.size() == 0) fail_now("err_unexpected");
        else begin
          ev_t e;
          e = err_q.pop_front();
          chk("err_cycle", 64'(cyc), 64'(e.cyc));
          chk("gain_cur_on_err", 64'(gain_cur), 64'(e.cur));
        end
      end
      if (cmpt_q.size() != 0 && cmpt_q[0].cyc < cyc) begin
        fail_now("cmpt_missing");
        void'(cmpt_q.pop_front());
      end
      if (err_q.size() != 0 && err_q[0].cyc < cyc) begin
        fail_now("err_missing");
        void'(err_q.pop_front());
      end
    end
  end

  // Serial frame decoder for both buses (index 0 = DAC, 1 = FDA).
  logic [1:0]  p_csn = 2'b11;
  logic [1:0]  p_sck = 2'b00;
  bit          in_fr [2];
  int          f_st [2], f_rise [2], f_nb [2];
  logic [31:0] f_sh [2];

  always @(negedge clk) begin : fmon
    logic [1:0] csn_v, sck_v, sdi_v;
    csn_v = {FDA_CSN, DAC_CSN};
    sck_v = {FDA_SCK, DAC_SCK};
    sdi_v = {FDA_SDI, DAC_SDI};
    if (!rst) begin
      in_fr[0] = 1'b0;
      in_fr[1] = 1'b0;
      p_csn = 2'b11;
      p_sck = 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (p_csn[b] && !csn_v[b]) begin
          in_fr[b] = 1'b1;
          f_st[b] = cyc;
          f_nb[b] = 0;
          f_sh[b] = '0;
          f_rise[b] = -1;
        end
        if (!p_sck[b] && sck_v[b]) begin
          if (!in_fr[b]) fail_now("sck_outside_frame");
          else begin
            f_sh[b] = {f_sh[b][30:0], sdi_v[b]};
            f_nb[b]++;
            if (f_nb[b] == 1) f_rise[b] = cyc;
          end
        end
        if (in_fr[b] && !p_csn[b] && csn_v[b]) begin
          in_fr[b] = 1'b0;
          if (fr_q.size() == 0 || fr_q[0].bus != b) fail_now("frame_unexpected");
          else begin
            fr_t x;
            x = fr_q.pop_front();
            chk("frame_data", 64'(f_sh[b]), 64'(x.data));
            chk("frame_bits", 64'(f_nb[b]), 64'(x.len));
            chk("csn_fall_cycle", 64'(f_st[b]), 64'(x.st));
            chk("first_rise_cycle", 64'(f_rise[b]), 64'(x.st + DIV));
            chk("csn_rise_cycle", 64'(cyc), 64'(x.st + (2 * x.len + 1) * DIV));
          end
        end
      end
      p_csn = csn_v;
      p_sck = sck_v;
    end
  end

  initial begin
    #600000;
    fail_now("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

  initial begin
    logic [GW-1:0] v;
    bit f;
    int d;
    rst = 1'b0;
    gain_en = 1'b0;
    gain_value = '0;
    gain_force = 1'b0;
    cap_gain_del = '0;
    for (int i = 0; i < GN; i++) begin
      t_dac_a[i] = $urandom;
      t_dac_b[i] = $urandom;
      t_lmh[i]   = LW'($urandom);
      t_relay[i] = RW'($urandom);
    end
    t_dac_a[3] = 32'hA5A5_0003;
    t_relay[3] = 4'hA;
    for (int i = 0; i < GN; i++) begin
      gain_dacA_tbl[i*DW +: DW]  = t_dac_a[i];
      gain_dacB_tbl[i*DW +: DW]  = t_dac_b[i];
      gain_lmh_tbl[i*LW +: LW]   = t_lmh[i];
      gain_relay_tbl[i*RW +: RW] = t_relay[i];
    end
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b1;

    req(4'd3, 1'b0, 10);  wait_idle();   // full sequence
    req(4'd3, 1'b0, 10);  wait_idle();   // same-gain skip
    req(4'd3, 1'b1, 10);  wait_idle();   // forced rewrite
    req(4'd9, 1'b0, 10);  wait_idle();   // out of range

    // Request arriving during the DACB frame of a running gain-2 sequence.
    req(4'd2, 1'b0, 7);
    while (cyc < last_c + 2 + 7 + FA + 20) @(posedge clk);
    req(4'd5, 1'b0, 7);
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      v = GW'($urandom_range(0, 9));
      if (i % 4 == 1) v = m_cur;
      f = ($urandom_range(0, 3) == 0);
      d = int'($urandom_range(0, 20));
      if (i == 2) d = 0;
      req(v, f, d);
      wait_idle();
    end

    // Reset in the middle of the FDA frame.
    req(4'd4, 1'b1, 5);
    while (cyc < last_c + 7 + 2 * FA + 40) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    check_reset("reset_mid_lmh");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    req(4'd6, 1'b0, 3);
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
